// File: rtl/speed_pkg.sv
// Shared types for the speed scheduler: game states and the fastest counter select.
package speed_pkg;
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} game_state_t;
    localparam logic [2:0] SEL_FASTEST = 3'd0;
endpackage

// File: rtl/speed_scheduler_msb_edge_det.sv
// Rising-edge detector on a single bit with a mask; the history bit is registered,
// the rise flag is combinational so the caller can register it alongside its own state.
module msb_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic in,
    input  logic mask,
    output logic rise
);
    logic msb_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            msb_q <= 1'b0;
        end else begin
            msb_q <= in;
        end
    end

    assign rise = in & ~msb_q & ~mask;
endmodule

// File: rtl/speed_scheduler.sv
// Game-flow controller: turns the selected counter's MSB into a row strobe, keeps the
// score and steps whichCounter toward faster counters every ROWS_PER_LEVEL rows.
module speed_scheduler
    import speed_pkg::*;
#(
    parameter int          ROWS_PER_LEVEL = 16,
    parameter logic [2:0]  START_SEL      = 3'd7,
    parameter int          SCORE_W        = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic               collision,
    input  logic [3:0]         MSB,
    output logic [2:0]         whichCounter,
    output logic               row_step,
    output logic [2:0]         level,
    output logic [SCORE_W-1:0] score,
    output logic               playing,
    output logic               game_over
);
    localparam logic [7:0] ROW_LAST = 8'(ROWS_PER_LEVEL - 1);

    game_state_t        state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [7:0]         row_cnt_q, row_cnt_d;
    logic               row_step_q, row_step_d;
    logic               suppress_q, suppress_d;
    logic               row_edge;
    logic               msb_low_unused;

    assign msb_low_unused = ^MSB[2:0];

    // The cycle after a select change the MSB source switches, so its first sample is not trusted.
    msb_edge_det u_row_edge (
        .CLK  (CLK),
        .RST  (RST),
        .in   (MSB[3]),
        .mask (suppress_q | (state_q != S_PLAY)),
        .rise (row_edge)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        score_d    = score_q;
        row_cnt_d  = row_cnt_q;
        row_step_d = 1'b0;
        suppress_d = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d    = S_PLAY;
                    score_d    = '0;
                    row_cnt_d  = 8'd0;
                    sel_d      = START_SEL;
                    suppress_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (collision) begin
                    state_d = S_OVER;
                end else if (row_edge) begin
                    row_step_d = 1'b1;
                    if (score_q != '1) begin
                        score_d = score_q + 1'b1;
                    end
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = 8'd0;
                        if (sel_q != SEL_FASTEST) begin
                            sel_d      = sel_q - 3'd1;
                            suppress_d = 1'b1;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            sel_q      <= START_SEL;
            score_q    <= '0;
            row_cnt_q  <= 8'd0;
            row_step_q <= 1'b0;
            suppress_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            score_q    <= score_d;
            row_cnt_q  <= row_cnt_d;
            row_step_q <= row_step_d;
            suppress_q <= suppress_d;
        end
    end

    assign whichCounter = sel_q;
    assign row_step     = row_step_q;
    assign score        = score_q;
    assign level        = START_SEL - sel_q;
    assign playing      = (state_q == S_PLAY);
    assign game_over    = (state_q == S_OVER);
endmodule

// File: tb/tb_speed_scheduler.sv
// Directed bench for speed_scheduler with ROWS_PER_LEVEL=4.
module tb_speed_scheduler;
    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        collision;
    logic [3:0]  MSB;
    logic [2:0]  whichCounter;
    logic        row_step;
    logic [2:0]  level;
    logic [15:0] score;
    logic        playing;
    logic        game_over;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    speed_scheduler #(.ROWS_PER_LEVEL(4), .START_SEL(3'd7), .SCORE_W(16)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .collision    (collision),
        .MSB          (MSB),
        .whichCounter (whichCounter),
        .row_step     (row_step),
        .level        (level),
        .score        (score),
        .playing      (playing),
        .game_over    (game_over)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Low then high on MSB[3]; the low nibble bits vary to show they are ignored.
    task automatic pulse_edge();
        MSB = 4'h7;
        step();
        MSB = 4'h8;
        step();
    endtask

    task automatic begin_game();
        MSB   = 4'h0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic hard_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; collision = 1'b0; MSB = 4'h0;
        #1;
        nvec++; if (whichCounter !== 3'd7) begin nerr++; $display("FAIL rst_sel got=%0d exp=7", whichCounter); end
        nvec++; if (score !== 16'd0) begin nerr++; $display("FAIL rst_score got=%0d exp=0", score); end
        nvec++; if (row_step !== 1'b0) begin nerr++; $display("FAIL rst_row_step got=%b exp=0", row_step); end
        nvec++; if (playing !== 1'b0 || game_over !== 1'b0) begin nerr++; $display("FAIL rst_flags got=%b%b exp=00", playing, game_over); end
        nvec++; if (level !== 3'd0) begin nerr++; $display("FAIL rst_level got=%0d exp=0", level); end
        RST = 1'b0;
        step();
        begin_game();
        repeat (5) pulse_edge();
        nvec++; if (score !== 16'd5) begin nerr++; $display("FAIL pre_rst_score got=%0d exp=5", score); end
        nvec++; if (whichCounter !== 3'd6) begin nerr++; $display("FAIL pre_rst_sel got=%0d exp=6", whichCounter); end
        // Async reset mid-cycle, while row_step is high.
        #2 RST = 1'b1;
        #1;
        nvec++; if (whichCounter !== 3'd7) begin nerr++; $display("FAIL midrst_sel got=%0d exp=7", whichCounter); end
        nvec++; if (score !== 16'd0) begin nerr++; $display("FAIL midrst_score got=%0d exp=0", score); end
        nvec++; if (playing !== 1'b0) begin nerr++; $display("FAIL midrst_playing got=%b exp=0", playing); end
        nvec++; if (row_step !== 1'b0) begin nerr++; $display("FAIL midrst_row_step got=%b exp=0", row_step); end
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_strobe();
        int pulses;
        hard_reset();
        begin_game();
        nvec++; if (playing !== 1'b1) begin nerr++; $display("FAIL strobe_playing got=%b exp=1", playing); end
        MSB = 4'h0;
        step();
        MSB = 4'h8;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (row_step === 1'b1) pulses++;
            if (i == 0) begin
                nvec++; if (row_step !== 1'b1) begin nerr++; $display("FAIL strobe_first got=%b exp=1", row_step); end
            end
        end
        nvec++; if (pulses != 1) begin nerr++; $display("FAIL strobe_count got=%0d exp=1", pulses); end
        nvec++; if (score !== 16'd1) begin nerr++; $display("FAIL strobe_score got=%0d exp=1", score); end
        // start is ignored while playing.
        start = 1'b1;
        step();
        start = 1'b0;
        nvec++; if (score !== 16'd1 || playing !== 1'b1) begin nerr++; $display("FAIL start_in_play score=%0d playing=%b exp=1/1", score, playing); end
    endtask

    task automatic test_level_step();
        hard_reset();
        begin_game();
        repeat (3) pulse_edge();
        nvec++; if (whichCounter !== 3'd7 || level !== 3'd0) begin nerr++; $display("FAIL lvl_before sel=%0d level=%0d exp=7/0", whichCounter, level); end
        pulse_edge();
        nvec++; if (whichCounter !== 3'd6) begin nerr++; $display("FAIL lvl_sel got=%0d exp=6", whichCounter); end
        nvec++; if (level !== 3'd1) begin nerr++; $display("FAIL lvl_level got=%0d exp=1", level); end
        nvec++; if (row_step !== 1'b1 || score !== 16'd4) begin nerr++; $display("FAIL lvl_edge row_step=%b score=%0d exp=1/4", row_step, score); end
        MSB = 4'h8;
        step();
        nvec++; if (row_step !== 1'b0) begin nerr++; $display("FAIL lvl_switch_cycle got=%b exp=0", row_step); end
        step();
        nvec++; if (row_step !== 1'b0 || score !== 16'd4) begin nerr++; $display("FAIL lvl_after row_step=%b score=%0d exp=0/4", row_step, score); end
    endtask

    task automatic test_saturation();
        logic [2:0] exp_sel;
        hard_reset();
        begin_game();
        for (int k = 1; k <= 32; k++) begin
            pulse_edge();
            exp_sel = (k / 4 >= 7) ? 3'd0 : 3'(7 - k / 4);
            if (k % 4 == 0) begin
                nvec++; if (whichCounter !== exp_sel) begin nerr++; $display("FAIL sat_sel k=%0d got=%0d exp=%0d", k, whichCounter, exp_sel); end
            end
        end
        nvec++; if (score !== 16'd32) begin nerr++; $display("FAIL sat_score got=%0d exp=32", score); end
        nvec++; if (level !== 3'd7) begin nerr++; $display("FAIL sat_level got=%0d exp=7", level); end
        repeat (3) pulse_edge();
        nvec++; if (whichCounter !== 3'd0 || score !== 16'd35) begin nerr++; $display("FAIL sat_wrap sel=%0d score=%0d exp=0/35", whichCounter, score); end
    endtask

    task automatic test_collision();
        logic [15:0] held;
        held = score;
        MSB = 4'h0;
        step();
        MSB = 4'h8;
        collision = 1'b1;
        step();
        collision = 1'b0;
        nvec++; if (row_step !== 1'b0) begin nerr++; $display("FAIL col_row_step got=%b exp=0", row_step); end
        nvec++; if (score !== held) begin nerr++; $display("FAIL col_score got=%0d exp=%0d", score, held); end
        nvec++; if (game_over !== 1'b1 || playing !== 1'b0) begin nerr++; $display("FAIL col_state over=%b playing=%b exp=1/0", game_over, playing); end
        repeat (2) pulse_edge();
        collision = 1'b1;
        step();
        collision = 1'b0;
        nvec++; if (score !== held || row_step !== 1'b0 || game_over !== 1'b1) begin nerr++; $display("FAIL col_frozen score=%0d row_step=%b over=%b exp=%0d/0/1", score, row_step, game_over, held); end
        nvec++; if (whichCounter !== 3'd0) begin nerr++; $display("FAIL col_sel_frozen got=%0d exp=0", whichCounter); end
    endtask

    task automatic test_restart();
        begin_game();
        nvec++; if (playing !== 1'b1 || game_over !== 1'b0) begin nerr++; $display("FAIL rs_state playing=%b over=%b exp=1/0", playing, game_over); end
        nvec++; if (score !== 16'd0 || whichCounter !== 3'd7 || level !== 3'd0) begin nerr++; $display("FAIL rs_init score=%0d sel=%0d level=%0d exp=0/7/0", score, whichCounter, level); end
        // Rising MSB during the suppress cycle must not count.
        MSB = 4'h8;
        step();
        nvec++; if (row_step !== 1'b0) begin nerr++; $display("FAIL rs_suppress got=%b exp=0", row_step); end
        step();
        nvec++; if (row_step !== 1'b0 || score !== 16'd0) begin nerr++; $display("FAIL rs_hold row_step=%b score=%0d exp=0/0", row_step, score); end
        pulse_edge();
        nvec++; if (row_step !== 1'b1 || score !== 16'd1) begin nerr++; $display("FAIL rs_first_edge row_step=%b score=%0d exp=1/1", row_step, score); end
    endtask

    initial begin
        test_reset();
        test_strobe();
        test_level_step();
        test_saturation();
        test_collision();
        test_restart();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
